// File: rtl/imem_responder.sv
// Instruction memory responder with a host-driven program loader.
// The memory returns mem[pc] combinationally while the core runs. The
// loader streams bytes in through a valid/ready port, and the core is held
// in reset until the image is resident.
module imem_responder #(
  parameter logic [7:0] NOP_WORD  = 8'h00,
  parameter bit         BOOT_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       async_rst_n,
  input  logic [7:0] pc,
  output logic [7:0] word,
  output logic       core_rst,
  input  logic       ld_start,
  input  logic [7:0] ld_addr,
  input  logic [7:0] ld_len,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       ld_abort,
  output logic       ld_busy,
  output logic       ld_done,
  output logic       ld_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // With BOOT_HOLD cleared, the block passes through RELEASE straight
  // out of reset, so the core starts without waiting for a load.
  localparam state_t RST_STATE = BOOT_HOLD ? IDLE : RELEASE;

  state_t      state_q, state_d;
  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        booted_q, booted_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic [7:0]  mem_q [256];

  // Control state: FSM, write pointer, remaining count, boot flag, pulses.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q  <= RST_STATE;
      wr_ptr_q <= 8'h00;
      cnt_q    <= 9'd0;
      booted_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      booted_q <= booted_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic for the loader FSM; an abort wins over a same-cycle byte.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    // Setting the flag while in RELEASE is equivalent to setting it on entry:
    // core_rst is held high for the whole RELEASE cycle regardless.
    booted_d = booted_q | (state_q == RELEASE);
    done_d   = 1'b0;
    err_d    = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          wr_ptr_d = ld_addr;
          // A length of zero encodes a full 256-byte image.
          cnt_d    = (ld_len == 8'h00) ? 9'd256 : {1'b0, ld_len};
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (ld_abort) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else if (ld_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 8'h01;
          cnt_d    = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            done_d  = 1'b1;
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory array is deliberately not reset so an image survives a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= ld_data;
    end
  end

  assign ld_busy  = (state_q == LOAD);
  assign ld_ready = (state_q == LOAD);
  assign ld_done  = done_q;
  assign ld_err   = err_q;
  assign core_rst = !booted_q || (state_q != IDLE);
  assign word     = ((state_q == IDLE) && !core_rst) ? mem_q[pc] : NOP_WORD;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: boot hold, loads, wrap, full-size
// image, abort, reset during a load and ld_start ignored in LOAD.
module tb_imem_responder;

  logic       clk;
  logic       async_rst_n;
  logic [7:0] pc;
  logic [7:0] word;
  logic       core_rst;
  logic       ld_start;
  logic [7:0] ld_addr;
  logic [7:0] ld_len;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_abort;
  logic       ld_busy;
  logic       ld_done;
  logic       ld_err;

  int n_cmp;
  int n_fail;

  imem_responder #(.NOP_WORD(8'h00), .BOOT_HOLD(1'b1)) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .pc         (pc),
    .word       (word),
    .core_rst   (core_rst),
    .ld_start   (ld_start),
    .ld_addr    (ld_addr),
    .ld_len     (ld_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_abort   (ld_abort),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done),
    .ld_err     (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] pcs [3];
    pcs[0] = 8'h00; pcs[1] = 8'h07; pcs[2] = 8'hFF;
    async_rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({core_rst, ld_ready, ld_busy, ld_done, ld_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 10000",
               {core_rst, ld_ready, ld_busy, ld_done, ld_err});
    end
    tick;
    async_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = pcs[i];
      tick;
      n_cmp++;
      if (core_rst !== 1'b1 || word !== 8'h00) begin
        n_fail++;
        $display("FAIL boot_hold pc=%h: core_rst=%b word=%h expected 1/00", pc, core_rst, word);
      end
    end
  endtask

  task automatic test_basic_load;
    logic [7:0] d [3];
    d[0] = 8'hA1; d[1] = 8'hB2; d[2] = 8'hC3;
    ld_start = 1'b1; ld_addr = 8'h00; ld_len = 8'd3;
    tick;
    ld_start = 1'b0;
    n_cmp++;
    if (ld_busy !== 1'b1 || ld_ready !== 1'b1 || core_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_enter_load: busy=%b ready=%b core_rst=%b expected 1/1/1",
               ld_busy, ld_ready, core_rst);
    end
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = d[i];
      tick;
      if (i < 2) begin
        n_cmp++;
        if (ld_done !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_early_done byte %0d: done=%b expected 0", i, ld_done);
        end
      end
    end
    ld_valid = 1'b0;
    pc = 8'h00;
    #1;
    n_cmp++;
    if (ld_done !== 1'b1 || ld_busy !== 1'b0 || core_rst !== 1'b1 || word !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_release: done=%b busy=%b core_rst=%b word=%h expected 1/0/1/00",
               ld_done, ld_busy, core_rst, word);
    end
    tick;
    n_cmp++;
    if (ld_done !== 1'b0 || core_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: done=%b core_rst=%b expected 0/0", ld_done, core_rst);
    end
    pc = 8'h01;
    #1;
    n_cmp++;
    if (word !== 8'hB2) begin
      n_fail++;
      $display("FAIL basic_read pc=01: got %h expected B2", word);
    end
    pc = 8'h00;
    #1;
    n_cmp++;
    if (word !== 8'hA1) begin
      n_fail++;
      $display("FAIL basic_read pc=00: got %h expected A1", word);
    end
    pc = 8'h02;
    #1;
    n_cmp++;
    if (word !== 8'hC3) begin
      n_fail++;
      $display("FAIL basic_read pc=02: got %h expected C3", word);
    end
  endtask

  task automatic test_wrap_stall;
    ld_start = 1'b1; ld_addr = 8'hFE; ld_len = 8'd3;
    tick;
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h11;
    tick;
    ld_valid = 1'b0; ld_data = 8'hEE;
    tick;
    tick;
    n_cmp++;
    if (ld_busy !== 1'b1 || ld_done !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_stall: busy=%b done=%b expected 1/0", ld_busy, ld_done);
    end
    ld_valid = 1'b1; ld_data = 8'h22;
    tick;
    ld_valid = 1'b0; ld_data = 8'hEE;
    tick;
    ld_valid = 1'b1; ld_data = 8'h33;
    tick;
    ld_valid = 1'b0;
    n_cmp++;
    if (ld_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_done: got %b expected 1", ld_done);
    end
    tick;
    pc = 8'hFE; #1;
    n_cmp++;
    if (word !== 8'h11) begin
      n_fail++;
      $display("FAIL wrap_read pc=FE: got %h expected 11", word);
    end
    pc = 8'hFF; #1;
    n_cmp++;
    if (word !== 8'h22) begin
      n_fail++;
      $display("FAIL wrap_read pc=FF: got %h expected 22", word);
    end
    pc = 8'h00; #1;
    n_cmp++;
    if (word !== 8'h33) begin
      n_fail++;
      $display("FAIL wrap_read pc=00: got %h expected 33", word);
    end
    pc = 8'h01; #1;
    n_cmp++;
    if (word !== 8'hB2) begin
      n_fail++;
      $display("FAIL wrap_untouched pc=01: got %h expected B2", word);
    end
  endtask

  task automatic test_len256;
    logic early;
    logic [7:0] exp;
    early = 1'b0;
    ld_start = 1'b1; ld_addr = 8'h00; ld_len = 8'h00;
    tick;
    ld_start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      ld_valid = 1'b1; ld_data = 8'(k) ^ 8'h5A;
      tick;
      if (k < 255 && (ld_done !== 1'b0 || ld_busy !== 1'b1)) early = 1'b1;
    end
    ld_valid = 1'b0;
    n_cmp++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL len256_early_end: got %b expected 0", early);
    end
    n_cmp++;
    if (ld_done !== 1'b1) begin
      n_fail++;
      $display("FAIL len256_done: got %b expected 1", ld_done);
    end
    tick;
    for (int k = 0; k < 256; k++) begin
      pc = 8'(k);
      exp = 8'(k) ^ 8'h5A;
      #1;
      n_cmp++;
      if (word !== exp) begin
        n_fail++;
        $display("FAIL len256_read pc=%h: got %h expected %h", pc, word, exp);
      end
    end
  endtask

  task automatic test_abort;
    ld_abort = 1'b1;
    tick;
    ld_abort = 1'b0;
    n_cmp++;
    if (ld_err !== 1'b0 || core_rst !== 1'b0 || ld_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_idle: err=%b core_rst=%b busy=%b expected 0/0/0",
               ld_err, core_rst, ld_busy);
    end
    ld_start = 1'b1; ld_addr = 8'h20; ld_len = 8'd4;
    tick;
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h71;
    tick;
    ld_data = 8'h72; ld_abort = 1'b1;
    tick;
    ld_valid = 1'b0; ld_abort = 1'b0;
    n_cmp++;
    if (ld_err !== 1'b1 || ld_done !== 1'b0 || ld_busy !== 1'b0 || core_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_release: err=%b done=%b busy=%b core_rst=%b expected 1/0/0/1",
               ld_err, ld_done, ld_busy, core_rst);
    end
    tick;
    n_cmp++;
    if (ld_err !== 1'b0 || ld_done !== 1'b0 || core_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: err=%b done=%b core_rst=%b expected 0/0/0",
               ld_err, ld_done, core_rst);
    end
    pc = 8'h20; #1;
    n_cmp++;
    if (word !== 8'h71) begin
      n_fail++;
      $display("FAIL abort_read pc=20: got %h expected 71", word);
    end
    pc = 8'h21; #1;
    n_cmp++;
    if (word !== 8'h7B) begin
      n_fail++;
      $display("FAIL abort_read pc=21: got %h expected 7B", word);
    end
  endtask

  task automatic test_reset_midload;
    int budget;
    ld_start = 1'b1; ld_addr = 8'h30; ld_len = 8'd5;
    tick;
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h91;
    tick;
    ld_valid = 1'b0;
    #2;
    async_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({core_rst, ld_ready, ld_busy, ld_done, ld_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL midload_reset: got %b expected 10000",
               {core_rst, ld_ready, ld_busy, ld_done, ld_err});
    end
    tick;
    async_rst_n = 1'b1;
    tick;
    n_cmp++;
    if (ld_done !== 1'b0 || ld_err !== 1'b0 || core_rst !== 1'b1 || ld_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_after: done=%b err=%b core_rst=%b busy=%b expected 0/0/1/0",
               ld_done, ld_err, core_rst, ld_busy);
    end
    // Fresh single-byte load.
    ld_start = 1'b1; ld_addr = 8'h40; ld_len = 8'd1;
    tick;
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hE1;
    budget = 0;
    tick;
    ld_valid = 1'b0;
    while (ld_done !== 1'b1 && budget < 10) begin
      tick;
      budget++;
    end
    n_cmp++;
    if (budget !== 0) begin
      n_fail++;
      $display("FAIL fresh_done_latency: extra cycles %0d expected 0", budget);
    end
    tick;
    pc = 8'h30; #1;
    n_cmp++;
    if (word !== 8'h91 || core_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_kept pc=30: word=%h core_rst=%b expected 91/0", word, core_rst);
    end
    pc = 8'h40; #1;
    n_cmp++;
    if (word !== 8'hE1) begin
      n_fail++;
      $display("FAIL fresh_read pc=40: got %h expected E1", word);
    end
    // ld_start inside LOAD must not restart or retarget the load.
    ld_start = 1'b1; ld_addr = 8'h50; ld_len = 8'd2;
    tick;
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hD1;
    tick;
    ld_start = 1'b1; ld_addr = 8'h80; ld_len = 8'd5;
    ld_data = 8'hD2;
    tick;
    ld_start = 1'b0; ld_valid = 1'b0;
    n_cmp++;
    if (ld_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_ignored_done: got %b expected 1", ld_done);
    end
    tick;
    pc = 8'h51; #1;
    n_cmp++;
    if (word !== 8'hD2) begin
      n_fail++;
      $display("FAIL restart_ignored pc=51: got %h expected D2", word);
    end
    pc = 8'h80; #1;
    n_cmp++;
    if (word !== 8'hDA) begin
      n_fail++;
      $display("FAIL restart_ignored pc=80: got %h expected DA", word);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    async_rst_n = 1'b0;
    pc = 8'h00; ld_start = 1'b0; ld_addr = 8'h00; ld_len = 8'h00;
    ld_valid = 1'b0; ld_data = 8'h00; ld_abort = 1'b0;
    test_reset;
    test_basic_load;
    test_wrap_stall;
    test_len256;
    test_abort;
    test_reset_midload;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
